match_controller: RTL and testbench
===================================

Name: match_controller

Overview:
- Sequences one Pong match: idle screen, serve countdown, live play, post-point pause, user pause, game over.
- Sits between the button/switch inputs and the ball, bar and score datapath.
- Gates ball motion, recentres the ball, keeps both scores, and supplies the countdown digit and winner flag to the graphics layer.
- Runs on mclk; all timing advances only on mclk cycles where tick=1 (one tick per game-logic step).

Parameters:
- MAX_SCORE, 5: score that wins the match; must be 1..7.
- SEC_TICKS, 60: ticks per countdown second.
- POINT_TICKS, 90: ticks the ball stays frozen after a point.

Ports:
- mclk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-mclk-cycle game-step enable.
- start  in  1  raw start/pause button, asynchronous level.
- point1  in  1  player 1 scored; sampled only when tick=1.
- point2  in  1  player 2 scored; sampled only when tick=1.
- ball_run  out  1  ball may move.
- ball_center  out  1  ball is held at court centre.
- serve_dir  out  1  direction of the next serve: 0 toward player 1, 1 toward player 2.
- score1  out  3  player 1 score.
- score2  out  3  player 2 score.
- countdown  out  2  digit shown during SERVE (3..1), 0 otherwise.
- playing  out  1  match in progress.
- winner  out  1  1 means player 1 won; valid only in OVER.
- state  out  3  current state code, for debug and LEDs.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, scores=0, serve_dir=0, winner=0, countdown=0.
  - All internal counters and synchronizer flops cleared.
- start input:
  - Passes through a 2-flop synchronizer, then a rising-edge detector.
  - start_evt is a single mclk pulse; it is not gated by tick.
- State codes: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSE=4, OVER=5. Codes 6 and 7 return to IDLE on the next cycle.
- Outputs by state:
  - ball_run=1 only in PLAY.
  - ball_center=1 in IDLE, SERVE and OVER.
  - playing=1 in SERVE, PLAY, POINT and PAUSE.
- IDLE and OVER: on start_evt, clear both scores, serve_dir=0, winner=0, load countdown=3 and the tick counter=0, go to SERVE.
- SERVE:
  - Each tick increments the tick counter.
  - When the counter reaches SEC_TICKS-1 on a tick, it resets to 0 and countdown decrements.
  - When countdown would go 1->0: countdown=0, go to PLAY.
  - SERVE therefore lasts exactly 3*SEC_TICKS ticks.
  - start_evt is ignored in SERVE.
- PLAY, on a tick:
  - point1 only: score1+1. If the new score1 equals MAX_SCORE, winner=1 and go to OVER; otherwise serve_dir=1 (serve toward the player who lost the point) and go to POINT.
  - point2 only: symmetric; score2+1, winner=0 on OVER, serve_dir=0.
  - point1 and point2 together: no score change, serve_dir unchanged, go to POINT.
  - start_evt in PLAY goes to PAUSE. If start_evt and a point arrive in the same cycle, the point wins.
- POINT:
  - Ball frozen (ball_run=0, ball_center=0).
  - After POINT_TICKS ticks, reload countdown=3 and the counter, go to SERVE.
  - start_evt is ignored.
- PAUSE:
  - Everything frozen and the tick counter holds.
  - start_evt returns to PLAY.
- Points arriving outside PLAY are ignored.
- Timing and widths:
  - All outputs are registered; state changes appear one mclk after the qualifying edge.
  - Scores are 3-bit and never exceed MAX_SCORE, so no wrap.
  - The tick counter is sized by $clog2(max(SEC_TICKS, POINT_TICKS)).
- reset asserted in any state returns immediately to the reset values; there are no partial updates.

Test Plan (SEC_TICKS=2, POINT_TICKS=3, MAX_SCORE=3, tick every 4th mclk):
- Reset then start pulse:
  - state IDLE->SERVE.
  - countdown reads 3,3,2,2,1,1 over 6 ticks, then state=PLAY with ball_run=1 and ball_center=0.
- In PLAY, point1 on a tick:
  - score1=1, serve_dir=1, state=POINT, ball_run=0.
  - After 3 ticks state=SERVE and countdown=3.
- point1 and point2 together in PLAY:
  - Scores unchanged, state=POINT, serve_dir unchanged.
- Three point2 events (each followed by its POINT and SERVE phases):
  - On the third, score2=3, state=OVER, winner=0, playing=0, ball_center=1.
  - A further point1 changes nothing.
  - Then start -> scores=0, state=SERVE.
- Pause:
  - start in PLAY gives state=PAUSE; ticks and point1 pulses are ignored and scores are unchanged.
  - A second start gives PLAY.
  - A start held high for 20 cycles causes only one transition.
- Mid-SERVE reset pulse (reset=0 for 1 mclk, asynchronous to mclk edge):
  - Outputs go to reset values immediately: state=IDLE, countdown=0, scores=0.

Source files
------------

// File: rtl/match_controller.sv
// Pong match sequencer: idle screen, serve countdown, live play, post-point
// freeze, user pause and game over. Keeps both scores and drives the ball
// gating, countdown digit and winner flag for the graphics layer.
module match_controller #(
    parameter int unsigned MAX_SCORE   = 5,
    parameter int unsigned SEC_TICKS   = 60,
    parameter int unsigned POINT_TICKS = 90
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       point1,
    input  logic       point2,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [2:0] score1,
    output logic [2:0] score2,
    output logic [1:0] countdown,
    output logic       playing,
    output logic       winner,
    output logic [2:0] state
);

    localparam int unsigned MAX_TICKS = (SEC_TICKS > POINT_TICKS) ? SEC_TICKS : POINT_TICKS;
    localparam int unsigned CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CNT_W-1:0] SEC_LAST   = CNT_W'(SEC_TICKS - 1);
    localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_TICKS - 1);
    localparam logic [2:0]       WIN_SCORE  = 3'(MAX_SCORE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_PAUSE = 3'd4,
        ST_OVER  = 3'd5
    } state_e;

    state_e           state_q,       state_d;
    logic [2:0]       score1_q,      score1_d;
    logic [2:0]       score2_q,      score2_d;
    logic             serve_dir_q,   serve_dir_d;
    logic             winner_q,      winner_d;
    logic [1:0]       countdown_q,   countdown_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic             ball_run_q,    ball_run_d;
    logic             ball_center_q, ball_center_d;
    logic             playing_q,     playing_d;

    // [0],[1] form the synchronizer; [2] holds the previous synchronized level
    logic [2:0]       start_sync_q;
    logic             start_evt;
    logic [2:0]       score1_inc;
    logic [2:0]       score2_inc;

    assign start_evt  = start_sync_q[1] & ~start_sync_q[2];
    assign score1_inc = score1_q + 3'd1;
    assign score2_inc = score2_q + 3'd1;

    // Bring the raw button into the mclk domain and keep one cycle of history
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            start_sync_q <= '0;
        end else begin
            start_sync_q <= {start_sync_q[1:0], start};
        end
    end

    // Next-state, score, countdown and tick-counter logic
    always_comb begin
        state_d     = state_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        serve_dir_d = serve_dir_q;
        winner_d    = winner_q;
        countdown_d = countdown_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_evt) begin
                    score1_d    = '0;
                    score2_d    = '0;
                    serve_dir_d = 1'b0;
                    winner_d    = 1'b0;
                    countdown_d = 2'd3;
                    cnt_d       = '0;
                    state_d     = ST_SERVE;
                end
            end

            ST_SERVE: begin
                if (tick) begin
                    if (cnt_q == SEC_LAST) begin
                        cnt_d = '0;
                        if (countdown_q == 2'd1) begin
                            countdown_d = '0;
                            state_d     = ST_PLAY;
                        end else begin
                            countdown_d = countdown_q - 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_PLAY: begin
                // A scored point takes priority over a pause request
                if (tick && (point1 || point2)) begin
                    cnt_d = '0;
                    if (point1 && point2) begin
                        state_d = ST_POINT;
                    end else if (point1) begin
                        score1_d = score1_inc;
                        if (score1_inc == WIN_SCORE) begin
                            winner_d = 1'b1;
                            state_d  = ST_OVER;
                        end else begin
                            serve_dir_d = 1'b1;
                            state_d     = ST_POINT;
                        end
                    end else begin
                        score2_d = score2_inc;
                        if (score2_inc == WIN_SCORE) begin
                            winner_d = 1'b0;
                            state_d  = ST_OVER;
                        end else begin
                            serve_dir_d = 1'b0;
                            state_d     = ST_POINT;
                        end
                    end
                end else if (start_evt) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_POINT: begin
                if (tick) begin
                    if (cnt_q == POINT_LAST) begin
                        cnt_d       = '0;
                        countdown_d = 2'd3;
                        state_d     = ST_SERVE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_PAUSE: begin
                if (start_evt) begin
                    state_d = ST_PLAY;
                end
            end

            default: begin
                countdown_d = '0;
                cnt_d       = '0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Ball gating and status flags, decoded from the next state so they register with it
    always_comb begin
        ball_run_d    = (state_d == ST_PLAY);
        ball_center_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) || (state_d == ST_OVER);
        playing_d     = (state_d == ST_SERVE) || (state_d == ST_PLAY) ||
                        (state_d == ST_POINT) || (state_d == ST_PAUSE);
    end

    // Match state register
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            score1_q      <= '0;
            score2_q      <= '0;
            serve_dir_q   <= 1'b0;
            winner_q      <= 1'b0;
            countdown_q   <= '0;
            cnt_q         <= '0;
            ball_run_q    <= 1'b0;
            ball_center_q <= 1'b1;
            playing_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            score1_q      <= score1_d;
            score2_q      <= score2_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            countdown_q   <= countdown_d;
            cnt_q         <= cnt_d;
            ball_run_q    <= ball_run_d;
            ball_center_q <= ball_center_d;
            playing_q     <= playing_d;
        end
    end

    assign state       = state_q;
    assign score1      = score1_q;
    assign score2      = score2_q;
    assign serve_dir   = serve_dir_q;
    assign winner      = winner_q;
    assign countdown   = countdown_q;
    assign ball_run    = ball_run_q;
    assign ball_center = ball_center_q;
    assign playing     = playing_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed match scenarios with literal checks,
// then randomized play, all compared every cycle against a ticks-remaining model.
module tb_match_controller;

    localparam int MAXS = 3;
    localparam int SEC  = 2;
    localparam int PT   = 3;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_POINT = 3;
    localparam int S_PAUSE = 4;
    localparam int S_OVER  = 5;

    logic       mclk   = 1'b0;
    logic       reset  = 1'b0;
    logic       tick   = 1'b0;
    logic       start  = 1'b0;
    logic       point1 = 1'b0;
    logic       point2 = 1'b0;
    logic       ball_run;
    logic       ball_center;
    logic       serve_dir;
    logic [2:0] score1;
    logic [2:0] score2;
    logic [1:0] countdown;
    logic       playing;
    logic       winner;
    logic [2:0] state;

    match_controller #(
        .MAX_SCORE  (MAXS),
        .SEC_TICKS  (SEC),
        .POINT_TICKS(PT)
    ) dut (
        .mclk       (mclk),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .point1     (point1),
        .point2     (point2),
        .ball_run   (ball_run),
        .ball_center(ball_center),
        .serve_dir  (serve_dir),
        .score1     (score1),
        .score2     (score2),
        .countdown  (countdown),
        .playing    (playing),
        .winner     (winner),
        .state      (state)
    );

    always #5 mclk = ~mclk;

    int total = 0;
    int bad   = 0;

    // Model: phase plus ticks remaining in that phase
    int m_state = S_IDLE;
    int m_s1 = 0, m_s2 = 0;
    int m_dir = 0, m_win = 0;
    int m_serve_left = 0, m_point_left = 0;
    int h1 = 0, h2 = 0, h3 = 0;   // raw start as sampled 1, 2, 3 edges ago

    function automatic void model_reset();
        m_state = S_IDLE; m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0;
        m_serve_left = 0; m_point_left = 0; h1 = 0; h2 = 0; h3 = 0;
    endfunction

    function automatic int m_countdown();
        return (m_state == S_SERVE) ? (m_serve_left + SEC - 1) / SEC : 0;
    endfunction

    function automatic void begin_serve();
        m_state = S_SERVE;
        m_serve_left = 3 * SEC;
    endfunction

    function automatic void begin_point();
        m_state = S_POINT;
        m_point_left = PT;
    endfunction

    function automatic void model_step();
        int evt;
        if (!reset) begin
            model_reset();
            return;
        end
        evt = (h2 == 1 && h3 == 0) ? 1 : 0;
        h3 = h2; h2 = h1; h1 = int'(start);
        case (m_state)
            S_IDLE, S_OVER: if (evt == 1) begin
                m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0;
                begin_serve();
            end
            S_SERVE: if (tick) begin
                m_serve_left--;
                if (m_serve_left == 0) m_state = S_PLAY;
            end
            S_PLAY: begin
                if (tick && point1 && point2) begin
                    begin_point();
                end else if (tick && point1) begin
                    m_s1++;
                    if (m_s1 == MAXS) begin m_win = 1; m_state = S_OVER; end
                    else begin m_dir = 1; begin_point(); end
                end else if (tick && point2) begin
                    m_s2++;
                    if (m_s2 == MAXS) begin m_win = 0; m_state = S_OVER; end
                    else begin m_dir = 0; begin_point(); end
                end else if (evt == 1) begin
                    m_state = S_PAUSE;
                end
            end
            S_POINT: if (tick) begin
                m_point_left--;
                if (m_point_left == 0) begin_serve();
            end
            S_PAUSE: if (evt == 1) m_state = S_PLAY;
            default: m_state = S_IDLE;
        endcase
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_all();
        chk("state",       int'(state),       m_state);
        chk("score1",      int'(score1),      m_s1);
        chk("score2",      int'(score2),      m_s2);
        chk("serve_dir",   int'(serve_dir),   m_dir);
        chk("winner",      int'(winner),      m_win);
        chk("countdown",   int'(countdown),   m_countdown());
        chk("ball_run",    int'(ball_run),    (m_state == S_PLAY) ? 1 : 0);
        chk("ball_center", int'(ball_center),
            (m_state == S_IDLE || m_state == S_SERVE || m_state == S_OVER) ? 1 : 0);
        chk("playing",     int'(playing),
            (m_state >= S_SERVE && m_state <= S_PAUSE) ? 1 : 0);
    endfunction

    // One mclk: drive at negedge, advance model at posedge, compare just after
    task automatic step(input bit st, input bit tk, input bit p1, input bit p2);
        @(negedge mclk);
        start = st; tick = tk; point1 = p1; point2 = p2;
        @(posedge mclk);
        model_step();
        #1;
        check_all();
    endtask

    // Four mclks with the tick on the last one
    task automatic tk_step(input bit p1, input bit p2);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, p1, p2);
    endtask

    task automatic press();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int cd_exp [6];
        int hold;
        bit st, a, b;
        cd_exp = '{3, 3, 2, 2, 1, 1};
        hold = 0;

        reset = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_state", int'(state), 0);
        chk("rst_countdown", int'(countdown), 0);
        chk("rst_scores", int'({score1, score2}), 0);
        chk("rst_center", int'(ball_center), 1);

        press();
        chk("start_serve", int'(state), 1);
        for (int unsigned i = 0; i < 6; i++) begin
            chk("cd_seq", int'(countdown), cd_exp[i]);
            tk_step(1'b0, 1'b0);
        end
        chk("serve_to_play", int'(state), 2);
        chk("model_play", m_state, 2);
        chk("play_run", int'(ball_run), 1);
        chk("play_center", int'(ball_center), 0);

        tk_step(1'b1, 1'b0);
        chk("p1_score", int'(score1), 1);
        chk("p1_dir", int'(serve_dir), 1);
        chk("p1_state", int'(state), 3);
        chk("p1_run", int'(ball_run), 0);
        chk("model_p1", m_s1, 1);
        repeat (3) tk_step(1'b0, 1'b0);
        chk("point_to_serve", int'(state), 1);
        chk("point_cd", int'(countdown), 3);
        repeat (6) tk_step(1'b0, 1'b0);

        tk_step(1'b1, 1'b1);
        chk("both_s1", int'(score1), 1);
        chk("both_s2", int'(score2), 0);
        chk("both_state", int'(state), 3);
        chk("both_dir", int'(serve_dir), 1);
        repeat (9) tk_step(1'b0, 1'b0);

        for (int unsigned k = 1; k <= 3; k++) begin
            tk_step(1'b0, 1'b1);
            if (k < 3) begin
                chk("p2_score", int'(score2), int'(k));
                chk("p2_dir", int'(serve_dir), 0);
                chk("p2_state", int'(state), 3);
                repeat (9) tk_step(1'b0, 1'b0);
            end else begin
                chk("over_score", int'(score2), 3);
                chk("over_state", int'(state), 5);
                chk("over_winner", int'(winner), 0);
                chk("over_playing", int'(playing), 0);
                chk("over_center", int'(ball_center), 1);
                chk("model_over", m_state, 5);
            end
        end
        tk_step(1'b1, 1'b0);
        chk("over_ignore_s1", int'(score1), 1);
        chk("over_ignore_state", int'(state), 5);

        press();
        chk("restart_scores", int'({score1, score2}), 0);
        chk("restart_state", int'(state), 1);
        repeat (6) tk_step(1'b0, 1'b0);
        chk("restart_play", int'(state), 2);

        press();
        chk("pause_state", int'(state), 4);
        repeat (3) tk_step(1'b1, 1'b0);
        chk("pause_s1", int'(score1), 0);
        chk("pause_hold", int'(state), 4);
        press();
        chk("unpause", int'(state), 2);

        repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("held_once", int'(state), 4);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("held_release", int'(state), 4);
        press();
        chk("held_resume", int'(state), 2);

        tk_step(1'b1, 1'b0);
        repeat (3) tk_step(1'b0, 1'b0);
        tk_step(1'b0, 1'b0);
        chk("pre_reset_serve", int'(state), 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("async_state", int'(state), 0);
        chk("async_countdown", int'(countdown), 0);
        chk("async_scores", int'({score1, score2}), 0);
        #10;
        reset = 1'b1;

        for (int unsigned n = 0; n < 2400; n++) begin
            if (hold == 0 && $urandom_range(0, 29) == 0) hold = int'($urandom_range(1, 6));
            st = (hold > 0);
            if (hold > 0) hold--;
            a = ($urandom_range(0, 5) == 0);
            b = ($urandom_range(0, 5) == 0);
            step(st, (n % 4) == 3, a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
